// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART definitions for the receiver and transmitter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int NTICK             = 16;
    localparam int START_MID         = 7;
    localparam int DEFAULT_DATA_BITS = 8;
    localparam int DEFAULT_STOP_BITS = 1;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START     = 5'b00010,
        DATA      = 5'b00100,
        STOP      = 5'b01000,
        WAIT_HIGH = 5'b10000
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchroniser for a single asynchronous bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/rx_uart.sv
// ============================================================================
// Module : rx_uart
// Brief  : 16x-oversampling UART receiver with glitch and framing detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_uart
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_ready,
    output logic                 o_frame_error,
    output logic                 o_busy
);

    localparam int c_CNT_W = $clog2(NTICK * STOP_BITS) + 1;
    localparam int c_BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CNT_W-1:0] c_START_MID = c_CNT_W'(START_MID);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(NTICK - 1);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST = c_CNT_W'(NTICK * STOP_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_t            r_state,     w_state_next;
    logic [c_CNT_W-1:0]   r_tick_cnt,  w_tick_cnt_next;
    logic [c_BIT_W-1:0]   r_bit_cnt,   w_bit_cnt_next;
    logic [DATA_BITS-1:0] r_shift,     w_shift_next;
    logic [DATA_BITS-1:0] r_data,      w_data_next;
    logic                 r_ready,     w_ready_next;
    logic                 r_ferr,      w_ferr_next;
    logic                 r_busy;

    sync_2ff #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    always_comb begin
        w_state_next    = r_state;
        w_tick_cnt_next = r_tick_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_shift_next    = r_shift;
        w_data_next     = r_data;
        w_ready_next    = 1'b0;
        w_ferr_next     = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Start edge is acted on without waiting for a tick so a
                // back-to-back frame loses no phase.
                if (!w_rx_s) begin
                    w_state_next    = START;
                    w_tick_cnt_next = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_START_MID) begin
                        w_tick_cnt_next = '0;
                        w_bit_cnt_next  = '0;
                        w_state_next    = w_rx_s ? IDLE : DATA;
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_BIT_LAST) begin
                        w_shift_next    = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_tick_cnt_next = '0;
                        if (r_bit_cnt == c_DATA_LAST) begin
                            w_state_next = STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == c_STOP_LAST) begin
                        w_tick_cnt_next = '0;
                        if (w_rx_s) begin
                            w_data_next  = r_shift;
                            w_ready_next = 1'b1;
                            w_state_next = IDLE;
                        end else begin
                            w_ferr_next  = 1'b1;
                            w_state_next = WAIT_HIGH;
                        end
                    end else begin
                        w_tick_cnt_next = r_tick_cnt + 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line recovers so a break is one error.
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_ready    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift    <= w_shift_next;
            r_data     <= w_data_next;
            r_ready    <= w_ready_next;
            r_ferr     <= w_ferr_next;
            r_busy     <= (w_state_next != IDLE);
        end
    end

    assign o_data        = r_data;
    assign o_data_ready  = r_ready;
    assign o_frame_error = r_ferr;
    assign o_busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rx_uart.sv
// ============================================================================
// Module : tb_rx_uart
// Brief  : Directed self-checking bench for rx_uart (1 and 2 stop-bit builds).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_uart;

    localparam int c_BIT_CLKS = 256;   // 16 ticks per bit, 16 clocks per tick

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx1;
    logic       rx2;
    logic [7:0] data1, data2;
    logic       rdy1, rdy2, ferr1, ferr2, busy1, busy2;

    int checks = 0;
    int errors = 0;

    int rdy1_cnt = 0, ferr1_cnt = 0, rdy2_cnt = 0, ferr2_cnt = 0;
    int lat_bad = 0, dbl = 0, both = 0;
    logic prev_rdy1 = 0, prev_ferr1 = 0, prev_rdy2 = 0, prev_ferr2 = 0;
    logic tick_q = 0;
    logic [7:0] log1 [0:31];

    rx_uart #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_tick        (tick),
        .i_rx          (rx1),
        .o_data        (data1),
        .o_data_ready  (rdy1),
        .o_frame_error (ferr1),
        .o_busy        (busy1)
    );

    rx_uart #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_tick        (tick),
        .i_rx          (rx2),
        .o_data        (data2),
        .o_data_ready  (rdy2),
        .o_frame_error (ferr2),
        .o_busy        (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            repeat (15) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // Tick value seen by the DUT at the edge that produced the current outputs.
    always @(posedge clk) tick_q <= tick;

    always @(negedge clk) begin
        if (rdy1) begin
            if (rdy1_cnt < 32) log1[rdy1_cnt] = data1;
            rdy1_cnt++;
            if (!tick_q) lat_bad++;
            if (prev_rdy1) dbl++;
        end
        if (ferr1) begin
            ferr1_cnt++;
            if (!tick_q) lat_bad++;
            if (prev_ferr1) dbl++;
        end
        if (rdy2) begin
            rdy2_cnt++;
            if (!tick_q) lat_bad++;
            if (prev_rdy2) dbl++;
        end
        if (ferr2) begin
            ferr2_cnt++;
            if (!tick_q) lat_bad++;
            if (prev_ferr2) dbl++;
        end
        if ((rdy1 && ferr1) || (rdy2 && ferr2)) both++;
        prev_rdy1  = rdy1;
        prev_ferr1 = ferr1;
        prev_rdy2  = rdy2;
        prev_ferr2 = ferr2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int line, input int clks);
        if (line == 1) rx1 = v;
        else           rx2 = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] b, input int line);
        drive_bit(1'b0, line, c_BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(b[i], line, c_BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] b, input int line);
        send_head(b, line);
        drive_bit(1'b1, line, c_BIT_CLKS);
    endtask

    initial begin
        rst = 1'b1;
        rx1 = 1'b1;
        rx2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data1", {24'd0, data1}, 32'h0);
        check("reset_flags1", {28'd0, rdy1, ferr1, busy1, 1'b0}, 32'h0);
        check("reset_data2", {24'd0, data2}, 32'h0);
        check("reset_flags2", {28'd0, rdy2, ferr2, busy2, 1'b0}, 32'h0);
        repeat (40) @(negedge clk);

        // 1: good frame
        send_frame(8'hA5, 1);
        check("t1_rdy_cnt", rdy1_cnt, 1);
        check("t1_log0", {24'd0, log1[0]}, 32'hA5);
        check("t1_data", {24'd0, data1}, 32'hA5);
        check("t1_ferr_cnt", ferr1_cnt, 0);
        check("t1_busy", {31'd0, busy1}, 32'h0);

        // 2: start glitch of 4 ticks
        rx1 = 1'b0;
        repeat (8) @(negedge clk);
        check("t2_busy_glitch", {31'd0, busy1}, 32'h1);
        repeat (56) @(negedge clk);
        drive_bit(1'b1, 1, 2 * c_BIT_CLKS);
        check("t2_rdy_cnt", rdy1_cnt, 1);
        check("t2_ferr_cnt", ferr1_cnt, 0);
        check("t2_data", {24'd0, data1}, 32'hA5);
        check("t2_busy", {31'd0, busy1}, 32'h0);

        // 3: framing error then line break
        send_head(8'h3C, 1);
        drive_bit(1'b0, 1, c_BIT_CLKS);
        drive_bit(1'b0, 1, 40 * 16);
        check("t3_ferr_cnt", ferr1_cnt, 1);
        check("t3_rdy_cnt_low", rdy1_cnt, 1);
        check("t3_busy_waithigh", {31'd0, busy1}, 32'h1);
        check("t3_data_kept", {24'd0, data1}, 32'hA5);
        drive_bit(1'b1, 1, c_BIT_CLKS);
        check("t3_busy_idle", {31'd0, busy1}, 32'h0);
        check("t3_ferr_once", ferr1_cnt, 1);
        send_frame(8'h81, 1);
        check("t3_rdy_cnt", rdy1_cnt, 2);
        check("t3_data_81", {24'd0, data1}, 32'h81);

        // 4: back-to-back frames
        send_frame(8'h00, 1);
        send_frame(8'hFF, 1);
        send_frame(8'h55, 1);
        check("t4_rdy_cnt", rdy1_cnt, 5);
        check("t4_log2", {24'd0, log1[2]}, 32'h00);
        check("t4_log3", {24'd0, log1[3]}, 32'hFF);
        check("t4_log4", {24'd0, log1[4]}, 32'h55);
        check("t4_ferr_cnt", ferr1_cnt, 1);
        drive_bit(1'b1, 1, c_BIT_CLKS);

        // 5: reset during data bit 4 of 0x96
        drive_bit(1'b0, 1, c_BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ^ i[1], 1, c_BIT_CLKS);
        drive_bit(1'b1, 1, 128);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_data_rst", {24'd0, data1}, 32'h0);
        check("t5_flags_rst", {28'd0, rdy1, ferr1, busy1, 1'b0}, 32'h0);
        drive_bit(1'b1, 1, 2 * c_BIT_CLKS);
        check("t5_rdy_cnt_idle", rdy1_cnt, 5);
        send_frame(8'h69, 1);
        check("t5_rdy_cnt", rdy1_cnt, 6);
        check("t5_data_69", {24'd0, data1}, 32'h69);
        check("t5_log5", {24'd0, log1[5]}, 32'h69);

        // 6: two stop bits
        send_head(8'hC3, 2);
        drive_bit(1'b1, 2, c_BIT_CLKS);
        check("t6_rdy2_early", rdy2_cnt, 0);
        check("t6_busy2_stop", {31'd0, busy2}, 32'h1);
        drive_bit(1'b1, 2, c_BIT_CLKS);
        check("t6_rdy2_cnt", rdy2_cnt, 1);
        check("t6_data2", {24'd0, data2}, 32'hC3);
        check("t6_busy2_idle", {31'd0, busy2}, 32'h0);
        send_head(8'h5A, 2);
        drive_bit(1'b1, 2, c_BIT_CLKS);
        drive_bit(1'b0, 2, c_BIT_CLKS);
        check("t6_ferr2_cnt", ferr2_cnt, 1);
        check("t6_rdy2_kept", rdy2_cnt, 1);
        check("t6_data2_kept", {24'd0, data2}, 32'hC3);
        drive_bit(1'b1, 2, c_BIT_CLKS);
        check("t6_busy2_end", {31'd0, busy2}, 32'h0);

        check("pulse_latency", lat_bad, 0);
        check("pulse_single", dbl, 0);
        check("pulse_exclusive", both, 0);
        check("dut1_ferr_final", ferr1_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rx_uart.md
Name: rx_uart

Overview:
- UART receiver: deserialises an asynchronous 8N1-style line into parallel words.
- Uses the shared 16x baud-rate tick generator.
- Counterpart of the team's transmitter. Output feeds the command/ALU interface logic with a one-cycle data-valid strobe.
- Detects start-bit glitches and framing errors.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first.
- STOP_BITS, 1, number of stop bits expected (1 or 2).

Ports:
- i_clock  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_tick  input  1  baud tick at 16x bit rate, one i_clock cycle wide.
- i_rx  input  1  serial line, idle high, asynchronous to i_clock.
- o_data  output  DATA_BITS  last correctly received word.
- o_data_ready  output  1  one-cycle pulse: o_data updated.
- o_frame_error  output  1  one-cycle pulse: stop bit sampled low.
- o_busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset: one clock, synchronous, active-high; overrides everything including i_tick. After reset:
  - state IDLE, tick and bit counters 0, shift register 0.
  - o_data=0, o_data_ready=0, o_frame_error=0, o_busy=0.
  - synchroniser flops =1.
- i_rx passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s (2-cycle input latency).
- Tick counter (4 bits plus headroom) advances only on cycles with i_tick=1. Nothing advances without a tick, except the IDLE->START transition.
- States (one-hot): IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 -> START, tick counter cleared.
  - Otherwise stay.
- START:
  - On tick with count==7 (bit middle): if rx_s==0 -> DATA, counters cleared; else glitch -> IDLE, no output pulse.
  - Otherwise count+1.
- DATA:
  - On tick with count==15: shift rx_s into MSB of shift register (right shift, LSB first), count=0.
  - If bit counter==DATA_BITS-1 -> STOP; else bit counter+1.
  - Otherwise count+1.
- STOP:
  - Counts 16*STOP_BITS ticks. At the final tick (count==16*STOP_BITS-1), sample rx_s.
  - rx_s==1: o_data <= shift register, o_data_ready=1 for exactly the next cycle, -> IDLE.
  - rx_s==0: o_frame_error=1 for exactly the next cycle, o_data unchanged, -> WAIT_HIGH.
  - For STOP_BITS=2, only the final stop-bit sample is checked.
- WAIT_HIGH:
  - Stays until rx_s==1, then -> IDLE.
  - Prevents a line break from producing repeated frames.
- o_data holds its value until the next good frame. o_data_ready and o_frame_error are never high together.
- Latency: o_data_ready asserts 1 clock after the i_tick at the middle of the last stop bit.
- Back-to-back frames: a start edge arriving immediately after the stop-bit sample is accepted. IDLE reacts in the same cycle it is entered.
- Reset mid-frame: frame discarded, no pulse, o_data cleared to 0.
- Tick rate tolerance: sampling at mid-bit tolerates roughly ±3% cumulative baud mismatch over 10 bits.

Decomposition:
- Shared uart_pkg holds:
  - state encodings IDLE/START/DATA/STOP/WAIT_HIGH.
  - NTICK=16, START_MID=7.
  - default DATA_BITS/STOP_BITS, shared with the transmitter.
- One sub-module: sync_2ff (2-flop synchroniser, reset value parameterised to 1).
- Counters and FSM stay in rx_uart, using registered state plus a combinational next-state block.

Test Plan:
1. Frame 0xA5 at 16 clocks/tick, 1 stop bit -> o_data_ready single pulse, o_data=0xA5, o_frame_error=0, o_busy low afterwards.
2. 4-tick-wide low glitch on an idle line -> returns to IDLE, no pulses, o_data unchanged.
3. Frame 0x3C with stop bit driven low, then line held low 40 ticks, then high -> one o_frame_error pulse, o_data keeps its previous value, no second frame until line high, next 0x81 received correctly.
4. Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three o_data_ready pulses with the values in order.
5. i_reset asserted during data bit 4 of frame 0x96 -> all outputs 0 on the next cycle; following frame 0x69 received correctly.
6. STOP_BITS=2 build, frame 0xC3 -> o_data_ready pulse only after 32 stop-state ticks; second stop bit low -> o_frame_error.
